// File: rtl/jump_sequencer.sv
// rtl/jump_sequencer.sv - MIPS program-counter sequencer; optional delay slot via JUMP_SEQ_DELAY_SLOT_EN
module jump_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        jump,
    input  logic        link,
    input  logic        jr,
    input  logic        branch_taken,
    input  logic [25:0] jump_index,
    input  logic [15:0] branch_offset,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] link_addr,
    output logic        link_we,
    output logic        misalign_err,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SLOT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic        link_we_q, link_we_d;
    logic        misalign_q, misalign_d;

    logic [31:0] j_tgt;
    logic [31:0] b_tgt;
    logic [31:0] sel_tgt;
    logic        redirect;

    assign pc_plus4 = pc_q + 32'd4;
    assign j_tgt    = {pc_plus4[31:28], jump_index, 2'b00};
    assign b_tgt    = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

`ifdef JUMP_SEQ_DELAY_SLOT_EN
    logic [31:0] tgt_q, tgt_d;
    localparam logic [31:0] LINK_OFS = 32'd8;
`else
    localparam logic [31:0] LINK_OFS = 32'd4;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        link_addr_d = link_addr_q;
        link_we_d   = 1'b0;
        misalign_d  = 1'b0;
        redirect    = 1'b0;
        sel_tgt     = pc_plus4;
`ifdef JUMP_SEQ_DELAY_SLOT_EN
        tgt_d       = tgt_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (jr && (jr_addr[1:0] != 2'b00)) begin
                        // Misaligned JR traps straight away, never through a delay slot
                        pc_d       = EXC_VECTOR;
                        misalign_d = 1'b1;
                    end else if (jr) begin
                        redirect = 1'b1;
                        sel_tgt  = jr_addr;
                    end else if (jump) begin
                        redirect = 1'b1;
                        sel_tgt  = j_tgt;
                    end else if (branch_taken) begin
                        redirect = 1'b1;
                        sel_tgt  = b_tgt;
                    end else begin
                        pc_d = pc_plus4;
                    end

                    if (redirect) begin
                        if (link && (jr || jump)) begin
                            link_we_d   = 1'b1;
                            link_addr_d = pc_q + LINK_OFS;
                        end
`ifdef JUMP_SEQ_DELAY_SLOT_EN
                        pc_d    = pc_plus4;
                        tgt_d   = sel_tgt;
                        state_d = ST_SLOT;
`else
                        pc_d    = sel_tgt;
`endif
                    end
                end
            end
`ifdef JUMP_SEQ_DELAY_SLOT_EN
            ST_SLOT: begin
                // Requests in the slot are dropped; a halt waits for the redirect to land
                if (!stall) begin
                    pc_d    = tgt_q;
                    state_d = halt ? ST_HALT : ST_RUN;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_VECTOR;
            link_addr_q <= 32'd0;
            link_we_q   <= 1'b0;
            misalign_q  <= 1'b0;
`ifdef JUMP_SEQ_DELAY_SLOT_EN
            tgt_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            link_addr_q <= link_addr_d;
            link_we_q   <= link_we_d;
            misalign_q  <= misalign_d;
`ifdef JUMP_SEQ_DELAY_SLOT_EN
            tgt_q       <= tgt_d;
`endif
        end
    end

    assign pc           = pc_q;
    assign link_addr    = link_addr_q;
    assign link_we      = link_we_q;
    assign misalign_err = misalign_q;
    assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_jump_sequencer.sv
// tb/tb_jump_sequencer.sv - directed vector bench for jump_sequencer
module tb_jump_sequencer;

    logic        clk;
    logic        reset;
    logic        stall, halt, jump, link, jr, branch_taken;
    logic [25:0] jump_index;
    logic [15:0] branch_offset;
    logic [31:0] jr_addr;
    logic [31:0] pc, pc_plus4, link_addr;
    logic        link_we, misalign_err, halted;

    int errors = 0;
    int checks = 0;

    jump_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .halt         (halt),
        .jump         (jump),
        .link         (link),
        .jr           (jr),
        .branch_taken (branch_taken),
        .jump_index   (jump_index),
        .branch_offset(branch_offset),
        .jr_addr      (jr_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .link_addr    (link_addr),
        .link_we      (link_we),
        .misalign_err (misalign_err),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, halt, jump, link, jr, br;
        logic [25:0] idx;
        logic [15:0] off;
        logic [31:0] jra;
        logic [31:0] e_pc;
        logic        e_lwe;
        logic [31:0] e_la;
        logic        e_mis;
        logic        e_hlt;
    } vec_t;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; jump = 0; link = 0; jr = 0; branch_taken = 0;
        jump_index = '0; branch_offset = '0; jr_addr = '0;
    endtask

    task automatic apply(input vec_t v, input int n);
        stall = v.stall; halt = v.halt; jump = v.jump; link = v.link;
        jr = v.jr; branch_taken = v.br;
        jump_index = v.idx; branch_offset = v.off; jr_addr = v.jra;
        @(posedge clk);
        #1;
        chk32($sformatf("v%0d_pc", n), pc, v.e_pc);
        chk1($sformatf("v%0d_link_we", n), link_we, v.e_lwe);
        if (v.e_lwe) chk32($sformatf("v%0d_link_addr", n), link_addr, v.e_la);
        chk1($sformatf("v%0d_misalign", n), misalign_err, v.e_mis);
        chk1($sformatf("v%0d_halted", n), halted, v.e_hlt);
    endtask

    function automatic vec_t mk(input logic s, input logic h, input logic j, input logic l,
                                input logic r, input logic b, input logic [25:0] idx,
                                input logic [15:0] off, input logic [31:0] jra,
                                input logic [31:0] e_pc, input logic e_lwe,
                                input logic [31:0] e_la, input logic e_mis, input logic e_hlt);
        vec_t v;
        v.stall = s; v.halt = h; v.jump = j; v.link = l; v.jr = r; v.br = b;
        v.idx = idx; v.off = off; v.jra = jra;
        v.e_pc = e_pc; v.e_lwe = e_lwe; v.e_la = e_la; v.e_mis = e_mis; v.e_hlt = e_hlt;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        idle_inputs();
        reset = 1'b1;

        // reset dropped mid-cycle, released on a falling edge
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk32("reset_pc", pc, 32'h0040_0000);
        chk1("reset_link_we", link_we, 1'b0);
        chk1("reset_misalign", misalign_err, 1'b0);
        chk1("reset_halted", halted, 1'b0);
        @(posedge clk);
        #1 chk32("reset_hold_pc", pc, 32'h0040_0000);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 chk32($sformatf("seq%0d_pc", i), pc, 32'h0040_0000 + 32'(4 * i));
        end

`ifdef JUMP_SEQ_DELAY_SLOT_EN
        // pc=0x0040000C: jump with link enters the slot, branch in slot is dropped
        vecs.push_back(mk(0,0,1,1,0,0,26'h0100040,16'h0,32'h0, 32'h0040_0010,1,32'h0040_0014,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,26'h0,16'h0010,32'h0,    32'h0040_0100,0,32'h0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,26'h0,16'h0,32'h0,       32'h0040_0104,0,32'h0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,26'h0,16'h0,32'h0040_0102,32'h8000_0180,0,32'h0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,26'h0,16'h0,32'h0,       32'h8000_0184,0,32'h0,0,0));
`else
        vecs.push_back(mk(0,0,0,0,0,0,26'h0,16'h0,32'h0,        32'h0040_0010,0,32'h0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,26'h0,16'h0,32'hF000_0010,32'hF000_0010,0,32'h0,0,0));
        vecs.push_back(mk(0,0,1,1,0,0,26'h0000004,16'h0,32'h0, 32'hF000_0010,1,32'hF000_0014,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,26'h0,16'h0,32'h0,        32'hF000_0014,0,32'h0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0,26'h0,16'h0,32'h0,        32'hF000_0018,0,32'h0,0,0));
        vecs.push_back(mk(0,0,0,1,1,0,26'h0,16'h0,32'h0,        32'h0000_0000,1,32'hF000_001C,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,26'h0,16'hFFFE,32'h0,     32'hFFFF_FFFC,0,32'h0,0,0));
        vecs.push_back(mk(1,0,1,1,0,0,26'h0000004,16'h0,32'h0, 32'hFFFF_FFFC,0,32'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,26'h0,16'h0,32'h0,        32'hFFFF_FFFC,0,32'h0,0,0));
        vecs.push_back(mk(0,0,1,0,0,1,26'h0100040,16'h0002,32'h0,32'h0040_0100,0,32'h0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,26'h0,16'h0010,32'h0,     32'h0040_0144,0,32'h0,0,0));
        vecs.push_back(mk(0,0,1,1,1,1,26'h0000004,16'h0004,32'h0040_0102,32'h8000_0180,0,32'h0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,26'h0,16'h0,32'h0,        32'h8000_0184,0,32'h0,0,0));
        vecs.push_back(mk(0,1,1,0,0,0,26'h0000004,16'h0,32'h0, 32'h8000_0184,0,32'h0,0,1));
        vecs.push_back(mk(0,0,0,1,1,0,26'h0,16'h0,32'h0,        32'h8000_0184,0,32'h0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,26'h0,16'h0010,32'h0,     32'h8000_0184,0,32'h0,0,1));
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i], i);
        end

        // reset leaves HALT
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        chk32("rst2_pc", pc, 32'h0040_0000);
        chk1("rst2_halted", halted, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk32("rst2_run_pc", pc, 32'h0040_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
